mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu.sv | 127 ++++++++++++
 tb/tb_mdu.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// Multiply/divide unit with architectural HI/LO registers.
// Results are computed at launch into shadow registers and committed after a fixed busy period.
module mdu #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [2:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int unsigned W  = 32;
   localparam int unsigned CW = 4;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   logic [0:0]    state, state_nxt;
   logic [CW-1:0] cnt, cnt_d;
   logic [W-1:0]  hi_nxt, lo_nxt, hi_nxt_d, lo_nxt_d;
   logic [W-1:0]  hi_d, lo_d;

   logic [2*W-1:0] prod_s, prod_u;
   logic [W-1:0]   abs_a, abs_b, div_u;
   logic [W-1:0]   q_mag, r_mag, q_s, r_s, q_u, r_u;

   // Datapath: products and sign-magnitude division (avoids signed overflow on 0x80000000 / -1)
   always_comb begin
      prod_s = {{W{A[W-1]}}, A} * {{W{B[W-1]}}, B};
      prod_u = {{W{1'b0}}, A} * {{W{1'b0}}, B};
      abs_a  = A[W-1] ? W'(-A) : A;
      abs_b  = (B == '0) ? W'(1) : (B[W-1] ? W'(-B) : B);
      div_u  = (B == '0) ? W'(1) : B;
      q_mag  = abs_a / abs_b;
      r_mag  = abs_a % abs_b;
      q_s    = (A[W-1] ^ B[W-1]) ? W'(-q_mag) : q_mag;
      r_s    = A[W-1] ? W'(-r_mag) : r_mag;
      q_u    = A / div_u;
      r_u    = A % div_u;
   end

   // Next-state and register-update logic
   always_comb begin
      state_nxt = state;
      cnt_d     = cnt;
      hi_d      = HI;
      lo_d      = LO;
      hi_nxt_d  = hi_nxt;
      lo_nxt_d  = lo_nxt;
      case (state)
         IDLE: begin
            if (en) begin
               case (op)
                  OP_MULT: begin
                     {hi_nxt_d, lo_nxt_d} = prod_s;
                     cnt_d     = CW'(MULT_CYCLES);
                     state_nxt = RUN;
                  end
                  OP_MULTU: begin
                     {hi_nxt_d, lo_nxt_d} = prod_u;
                     cnt_d     = CW'(MULT_CYCLES);
                     state_nxt = RUN;
                  end
                  OP_DIV: begin
                     // divide by zero re-commits the current HI/LO, which cannot change while busy
                     hi_nxt_d  = (B == '0) ? HI : r_s;
                     lo_nxt_d  = (B == '0) ? LO : q_s;
                     cnt_d     = CW'(DIV_CYCLES);
                     state_nxt = RUN;
                  end
                  OP_DIVU: begin
                     hi_nxt_d  = (B == '0) ? HI : r_u;
                     lo_nxt_d  = (B == '0) ? LO : q_u;
                     cnt_d     = CW'(DIV_CYCLES);
                     state_nxt = RUN;
                  end
                  OP_MTHI: hi_d = A;
                  OP_MTLO: lo_d = A;
                  default: ;
               endcase
            end
         end
         RUN: begin
            cnt_d = cnt - CW'(1);
            if (cnt == CW'(1)) begin
               state_nxt = IDLE;
               hi_d      = hi_nxt;
               lo_d      = lo_nxt;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= IDLE;
         cnt    <= '0;
         busy   <= 1'b0;
         HI     <= '0;
         LO     <= '0;
         hi_nxt <= '0;
         lo_nxt <= '0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_d;
         busy   <= (state_nxt == RUN);
         HI     <= hi_d;
         LO     <= lo_d;
         hi_nxt <= hi_nxt_d;
         lo_nxt <= lo_nxt_d;
      end
   end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: per-cycle comparison against a behavioural model plus directed literal checks.
module tb_mdu;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic [2:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_on   = 1'b0;

   localparam int MC = 5;
   localparam int DC = 10;

   mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .en(en), .op(op), .A(A), .B(B),
      .busy(busy), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural result of an operation: {valid, hi, lo}; valid=0 means no commit
   function automatic logic [64:0] model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint r;
      case (o)
         3'd1: begin r = sa * sb; return {1'b1, 64'(r)}; end
         3'd2: return {1'b1, 64'(a) * 64'(b)};
         3'd3: begin
            if (b == 32'd0) return 65'd0;
            return {1'b1, 32'(sa % sb), 32'(sa / sb)};
         end
         3'd4: begin
            if (b == 32'd0) return 65'd0;
            return {1'b1, a % b, a / b};
         end
         default: return 65'd0;
      endcase
   endfunction

   logic        m_busy;
   int          m_left;
   logic [64:0] m_res;
   logic [31:0] m_hi, m_lo;

   always @(posedge clk) begin
      if (!reset) begin
         m_busy <= 1'b0;
         m_left <= 0;
         m_res  <= '0;
         m_hi   <= '0;
         m_lo   <= '0;
      end else if (m_busy) begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_busy <= 1'b0;
            if (m_res[64]) begin
               m_hi <= m_res[63:32];
               m_lo <= m_res[31:0];
            end
         end
      end else if (en) begin
         if (op >= 3'd1 && op <= 3'd4) begin
            m_res  <= model_op(op, A, B);
            m_busy <= 1'b1;
            m_left <= (op <= 3'd2) ? MC : DC;
         end else if (op == 3'd5) begin
            m_hi <= A;
         end else if (op == 3'd6) begin
            m_lo <= A;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_on) begin
         check("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
         check("cyc_hi", HI, m_hi);
         check("cyc_lo", LO, m_lo);
      end
   end

   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      en = 1'b1; op = o; A = a; B = b;
      @(negedge clk);
      en = 1'b0; op = 3'd0;
   endtask

   // Counts busy cycles from the negedge after launch; bounded in case busy sticks
   task automatic count_busy(input string name, input int exp_n);
      int n = 0;
      while (busy === 1'b1 && n < 40) begin
         n++;
         @(negedge clk);
      end
      check(name, 32'(n), 32'(exp_n));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [64:0] r;
      int n;
      reset = 1'b0; en = 1'b0; op = 3'd0; A = '0; B = '0;

      r = model_op(3'd3, 32'h80000000, 32'hFFFFFFFF);
      check("model_div_ovf_lo", r[31:0], 32'h80000000);
      check("model_div_ovf_hi", r[63:32], 32'h00000000);
      r = model_op(3'd3, 32'hFFFFFFF9, 32'd2);
      check("model_div_neg_hi", r[63:32], 32'hFFFFFFFF);
      r = model_op(3'd4, 32'h5, 32'd0);
      check("model_div0_valid", {31'd0, r[64]}, 32'd0);

      repeat (3) @(negedge clk);
      reset = 1'b1;
      cmp_on = 1'b1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_hi", HI, 32'd0);
      check("rst_lo", LO, 32'd0);

      issue(3'd1, 32'hFFFFFFFF, 32'h00000002);
      count_busy("mult_busy_len", 5);
      check("mult_hi", HI, 32'hFFFFFFFF);
      check("mult_lo", LO, 32'hFFFFFFFE);

      issue(3'd2, 32'hFFFFFFFF, 32'h00000002);
      count_busy("multu_busy_len", 5);
      check("multu_hi", HI, 32'h00000001);
      check("multu_lo", LO, 32'hFFFFFFFE);

      issue(3'd3, 32'hFFFFFFF9, 32'd2);
      count_busy("div_busy_len", 10);
      check("div_lo", LO, 32'hFFFFFFFD);
      check("div_hi", HI, 32'hFFFFFFFF);

      issue(3'd4, 32'd7, 32'd2);
      count_busy("divu_busy_len", 10);
      check("divu_lo", LO, 32'd3);
      check("divu_hi", HI, 32'd1);

      issue(3'd5, 32'h12345678, 32'd0);
      check("mthi_busy", {31'd0, busy}, 32'd0);
      check("mthi_hi", HI, 32'h12345678);
      issue(3'd3, 32'd5, 32'd0);
      count_busy("div0_busy_len", 10);
      check("div0_hi", HI, 32'h12345678);
      check("div0_lo", LO, 32'd3);

      // MULT with MTLO and a second MULT issued on RUN cycles 2 and 3
      @(negedge clk);
      en = 1'b1; op = 3'd1; A = 32'd3; B = 32'd7;
      n = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (busy === 1'b1) n++;
         en = (k == 1 || k == 2);
         op = (k == 1) ? 3'd6 : 3'd1;
         A  = (k == 1) ? 32'hDEADBEEF : 32'd100;
         B  = 32'd100;
      end
      en = 1'b0; op = 3'd0;
      check("ignore_busy_len", 32'(n), 32'd5);
      check("ignore_lo", LO, 32'd21);
      check("ignore_hi", HI, 32'd0);

      issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
      count_busy("ovf_busy_len", 10);
      check("ovf_lo", LO, 32'h80000000);
      check("ovf_hi", HI, 32'h00000000);
      en = 1'b1; op = 3'd2; A = 32'h00010000; B = 32'h00010000;
      @(negedge clk);
      en = 1'b0; op = 3'd0;
      check("b2b_busy", {31'd0, busy}, 32'd1);
      count_busy("b2b_busy_len", 5);
      check("b2b_hi", HI, 32'd1);
      check("b2b_lo", LO, 32'd0);

      issue(3'd7, 32'hAAAA5555, 32'd1);
      issue(3'd0, 32'hAAAA5555, 32'd1);
      @(negedge clk);
      op = 3'd5; A = 32'hCAFEF00D;
      @(negedge clk);
      op = 3'd0;
      check("nop_busy", {31'd0, busy}, 32'd0);
      check("nop_hi", HI, 32'd1);
      check("nop_lo", LO, 32'd0);

      issue(3'd3, 32'd100, 32'd7);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_hi", HI, 32'd0);
      check("abort_lo", LO, 32'd0);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("abort_idle_busy", {31'd0, busy}, 32'd0);
         check("abort_idle_hi", HI, 32'd0);
         check("abort_idle_lo", LO, 32'd0);
      end

      cmp_on = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
